// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Purpose:
//   Time-multiplexes NUM_DIGITS hex digits onto a shared set of active-low
//   seven-segment cathodes. Each digit has an enable and a decimal point, and
//   all digits share a PWM brightness code. The inputs are captured as one
//   coherent snapshot at the end of every scan frame, so a digit value can
//   never change partway through a frame (no tearing).
//
// Optional feature:
//   SSD_LZB_EN - when defined, leading zeros are blanked at snapshot time.
//                Digit k (k >= 1) is blanked if it and every higher enabled
//                digit hold 0 with the decimal point off. Disabled digits are
//                transparent to that chain. Digit 0 is never blanked.
//
// Parameters:
//   NUM_DIGITS  number of digits / anodes (1..8)
//   SCAN_DIV_W  prescaler width; one digit slot lasts 2^SCAN_DIV_W clocks
//   BRIGHT_W    brightness code width (<= SCAN_DIV_W)
//
// Ports:
//   ClkPort     system clock
//   Reset_n     synchronous active-low reset
//   digits_in   packed hex digits, digit k = [4k+3:4k], digit 0 rightmost
//   dp_in       per-digit decimal point, 1 = lit
//   digit_en    per-digit enable, 0 = anode held off for its slot
//   brightness  on-time code, duty = code / 2^BRIGHT_W, 0 = dark
//   An          anodes, active low, registered
//   Cathodes    {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low, registered
//   frame_done  one-cycle pulse on the clock a snapshot is taken
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV_W = 18,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    ClkPort,
    input  logic                    Reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cathodes,
    output logic                    frame_done
);

    localparam int                SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    // Segment pattern {a,b,c,d,e,f,g}, active low.
    function automatic logic [6:0] seg7(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Scan timing state
    logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  load_pending_q, load_pending_d;

    // Frame snapshot
    logic [NUM_DIGITS-1:0][3:0] digit_snap_q, digit_snap_d;
    logic [NUM_DIGITS-1:0]      dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]      en_snap_q, en_snap_d;
    logic [BRIGHT_W-1:0]        bright_snap_q, bright_snap_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            cath_q, cath_d;
    logic                  frame_done_q, frame_done_d;

    logic                  cnt_wrap;
    logic                  snap_take;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] en_load;  // enable mask as it will be stored in the snapshot

`ifdef SSD_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic                  lzb_chain;

    // Walk from the most significant digit down; the chain stays alive only
    // while every enabled digit seen so far is a plain zero.
    always_comb begin
        lzb_mask  = '0;
        lzb_chain = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (digit_en[k]) begin
                if (digits_in[4*k +: 4] == 4'h0 && !dp_in[k]) begin
                    lzb_mask[k] = lzb_chain;
                end else begin
                    lzb_chain = 1'b0;
                end
            end
        end
    end

    assign en_load = digit_en & ~lzb_mask;
`else
    assign en_load = digit_en;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        cnt_wrap  = &cnt_q;
        snap_take = load_pending_q || (cnt_wrap && slot_q == LAST_SLOT);

        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_wrap) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end

        // The pending flag only ever survives the first clock out of reset,
        // and that clock always takes a snapshot.
        load_pending_d = 1'b0;

        digit_snap_d  = digit_snap_q;
        dp_snap_d     = dp_snap_q;
        en_snap_d     = en_snap_q;
        bright_snap_d = bright_snap_q;
        if (snap_take) begin
            digit_snap_d  = digits_in;
            dp_snap_d     = dp_in;
            en_snap_d     = en_load;
            bright_snap_d = brightness;
        end
        frame_done_d = snap_take;

        // The top bits of the prescaler form a ramp that the brightness code
        // is compared against, giving code/2^BRIGHT_W on-time per slot.
        an_on  = en_snap_q[slot_q] && (cnt_q[SCAN_DIV_W-1 -: BRIGHT_W] < bright_snap_q);
        an_d   = '1;
        cath_d = 8'hFF;  // blank cathodes while the anode is off to avoid ghosting
        if (an_on) begin
            an_d[slot_q] = 1'b0;
            cath_d       = {seg7(digit_snap_q[slot_q]), ~dp_snap_q[slot_q]};
        end
    end

    always_ff @(posedge ClkPort) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!Reset_n) begin
            cnt_q          <= '0;
            slot_q         <= '0;
            load_pending_q <= 1'b1;
            // NOTE: the snapshot is cleared on reset because the output stage
            // reads it on the very first clock, before any capture lands.
            digit_snap_q   <= '0;
            dp_snap_q      <= '0;
            en_snap_q      <= '0;
            bright_snap_q  <= '0;
            an_q           <= '1;
            cath_q         <= 8'hFF;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            load_pending_q <= load_pending_d;
            digit_snap_q   <= digit_snap_d;
            dp_snap_q      <= dp_snap_d;
            en_snap_q      <= en_snap_d;
            bright_snap_q  <= bright_snap_d;
            an_q           <= an_d;
            cath_q         <= cath_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign An         = an_q;
    assign Cathodes   = cath_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// Drives ssd_scan_driver (4 digits, 16-clock slots, 2-bit brightness) through
// directed scenarios followed by randomized input changes and resets. The
// expected outputs come from a reference model that works from the index of
// each clock edge since reset release: slot and ramp position are derived by
// division, snapshots happen on edge 0 and every 64th edge thereafter.
// Honours SSD_LZB_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int SW = 4;
    localparam int BW = 2;
    localparam int SLOT_CLKS  = 1 << SW;
    localparam int FRAME_CLKS = SLOT_CLKS * ND;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   en;
    logic [BW-1:0]   bright;
    logic [ND-1:0]   an;
    logic [7:0]      cath;
    logic            fd;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV_W (SW),
        .BRIGHT_W   (BW)
    ) dut (
        .ClkPort    (clk),
        .Reset_n    (rst_n),
        .digits_in  (digits),
        .dp_in      (dp),
        .digit_en   (en),
        .brightness (bright),
        .An         (an),
        .Cathodes   (cath),
        .frame_done (fd)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int            m_e;      // index of the next clock edge since reset release
    logic [15:0]   s_dig;
    logic [ND-1:0] s_dp;
    logic [ND-1:0] s_en;
    logic [BW-1:0] s_br;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Window statistics
    bit counting = 1'b0;
    int low_cnt [ND];
    int fd_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, m_e, got, exp);
        end
    endtask

    task automatic capture();
        bit blank;
        s_dig = digits;
        s_dp  = dp;
        s_en  = en;
        s_br  = bright;
`ifdef SSD_LZB_EN
        for (int k = 1; k < ND; k++) begin
            blank = 1'b1;
            for (int j = k; j < ND; j++) begin
                if (en[j] && !(digits[j*4 +: 4] == 4'h0 && dp[j] == 1'b0)) blank = 1'b0;
            end
            if (blank) s_en[k] = 1'b0;
        end
`endif
    endtask

    task automatic tick();
        logic [ND-1:0] e_an;
        logic [7:0]    e_cath;
        logic          e_fd;
        int            pos;
        int            slot;
        bit            on;
        if (!rst_n) begin
            e_an   = '1;
            e_cath = 8'hFF;
            e_fd   = 1'b0;
        end else begin
            pos    = m_e % SLOT_CLKS;
            slot   = (m_e / SLOT_CLKS) % ND;
            on     = s_en[slot] && ((pos / (SLOT_CLKS >> BW)) < int'(s_br));
            e_an   = on ? ~(ND'(1) << slot) : '1;
            e_cath = on ? {seg_tab[s_dig[slot*4 +: 4]], ~s_dp[slot]} : 8'hFF;
            e_fd   = (m_e == 0) || (m_e % FRAME_CLKS == FRAME_CLKS - 1);
        end
        @(posedge clk);
        #1;
        check("An", 32'(an), 32'(e_an));
        check("Cathodes", 32'(cath), 32'(e_cath));
        check("frame_done", 32'(fd), 32'(e_fd));
        if (counting) begin
            for (int k = 0; k < ND; k++) if (!an[k]) low_cnt[k]++;
            if (fd) fd_cnt++;
        end
        if (!rst_n) begin
            m_e   = 0;
            s_dig = '0;
            s_dp  = '0;
            s_en  = '0;
            s_br  = '0;
        end else begin
            if (e_fd) capture();
            m_e++;
        end
    endtask

    // Count anode-low clocks per digit over one full frame of outputs.
    task automatic window_count();
        for (int k = 0; k < ND; k++) low_cnt[k] = 0;
        fd_cnt   = 0;
        counting = 1'b1;
        repeat (FRAME_CLKS) tick();
        counting = 1'b0;
    endtask

    // Let a new input set reach a snapshot, then stop at a frame boundary.
    task automatic settle_to_frame();
        tick();
        while (m_e % FRAME_CLKS != 0) tick();
    endtask

    initial begin
        m_e    = 0;
        s_dig  = '0;
        s_dp   = '0;
        s_en   = '0;
        s_br   = '0;

        // Reset held for 5 clocks
        rst_n  = 1'b0;
        digits = 16'h3A07;
        en     = 4'hF;
        dp     = 4'b0100;
        bright = 2'd3;
        repeat (5) tick();
        check("reset_An", 32'(an), 32'hF);
        check("reset_Cathodes", 32'(cath), 32'hFF);
        check("reset_frame_done", 32'(fd), 32'h0);

        // First clock after release takes a snapshot
        rst_n = 1'b1;
        tick();
        check("release_frame_done", 32'(fd), 32'h1);

        // Full-brightness scan: 12 of 16 clocks per slot, one pulse per frame
        repeat (FRAME_CLKS - 1) tick();
        window_count();
        for (int k = 0; k < ND; k++) check($sformatf("s2_low_d%0d", k), 32'(low_cnt[k]), 32'd12);
        check("s2_frame_pulses", 32'(fd_cnt), 32'd1);

        // Slot 2, first ramp step: digit A with its decimal point lit
        repeat (2 * SLOT_CLKS + 1) tick();
        check("s2_slot2_An", 32'(an), 32'b1011);
        check("s2_slot2_Cathodes", 32'(cath), 32'h10);

        // Mid-frame change during slot 1 waits for the next frame
        while (m_e % FRAME_CLKS != SLOT_CLKS + 4) tick();
        digits = 16'hFFFF;
        while (m_e % FRAME_CLKS != 2 * SLOT_CLKS + 3) tick();
        check("s3_slot2_still_A", 32'(cath), 32'h10);
        while (m_e % FRAME_CLKS != 1) tick();
        check("s3_next_frame_F", 32'(cath), 32'h71);

        // Two digits disabled, quarter brightness
        en     = 4'b1010;
        bright = 2'd1;
        settle_to_frame();
        window_count();
        check("s4_low_d0", 32'(low_cnt[0]), 32'd0);
        check("s4_low_d1", 32'(low_cnt[1]), 32'd4);
        check("s4_low_d2", 32'(low_cnt[2]), 32'd0);
        check("s4_low_d3", 32'(low_cnt[3]), 32'd4);

        // One-clock reset during slot 2
        while (m_e % FRAME_CLKS != 2 * SLOT_CLKS + 8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("s5_release_frame_done", 32'(fd), 32'h1);
        check("s5_release_An", 32'(an), 32'hF);

        // Leading-zero patterns
        digits = 16'h0050;
        en     = 4'hF;
        dp     = 4'b0000;
        bright = 2'd3;
        settle_to_frame();
        window_count();
`ifdef SSD_LZB_EN
        check("s6_0050_d3", 32'(low_cnt[3]), 32'd0);
        check("s6_0050_d2", 32'(low_cnt[2]), 32'd0);
`else
        check("s6_0050_d3", 32'(low_cnt[3]), 32'd12);
        check("s6_0050_d2", 32'(low_cnt[2]), 32'd12);
`endif
        check("s6_0050_d1", 32'(low_cnt[1]), 32'd12);
        check("s6_0050_d0", 32'(low_cnt[0]), 32'd12);

        digits = 16'h0000;
        settle_to_frame();
        window_count();
        check("s6_0000_d0", 32'(low_cnt[0]), 32'd12);
`ifdef SSD_LZB_EN
        check("s6_0000_d3", 32'(low_cnt[3]), 32'd0);
        check("s6_0000_d1", 32'(low_cnt[1]), 32'd0);
`else
        check("s6_0000_d3", 32'(low_cnt[3]), 32'd12);
        check("s6_0000_d1", 32'(low_cnt[1]), 32'd12);
`endif

        // Randomized input changes and occasional resets
        repeat (1500) begin
            if ($urandom_range(7) == 0) begin
                for (int k = 0; k < ND; k++) begin
                    digits[k*4 +: 4] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
                end
                dp     = 4'($urandom_range(15)) & 4'($urandom_range(15));
                en     = 4'($urandom_range(15)) | 4'($urandom_range(15));
                bright = 2'($urandom_range(3));
            end
            rst_n = ($urandom_range(199) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (FRAME_CLKS) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
